// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FWFT read-side adapter.
// Holds the occupancy type, buffer depth and the "words owned" level helper.
package fifo_rd_pkg;

    // Number of words the adapter can hold (buffered + in flight).
    localparam int unsigned FWFT_DEPTH = 2;

    // Buffer occupancy, legal values 0..2.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // Upper bound on words owned after this cycle for a new pop to be allowed.
    localparam logic [2:0] LEVEL_LIMIT = 3'd2;

    // Words owned by the adapter at the next edge before any new pop request:
    // buffered words plus the word arriving now, minus the word leaving now.
    function automatic logic [2:0] fwft_level(
        input occ_t occ,
        input logic inflight,
        input logic pop
    );
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry storage for the FWFT adapter: write pointer, read pointer and
// occupancy. Pointers are single bits so they wrap modulo 2 by construction.
// Writes into a full buffer and reads from an empty buffer are ignored so the
// occupancy can never leave the 0..2 range.
module fifo_rd_skid2
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output occ_t                  o_occ,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [FWFT_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    occ_t                  r_occ;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    occ_t                  w_occ_next;

    // Qualify the raw requests against the current occupancy.
    always_comb begin
        w_wr_ok = 1'b0;
        w_rd_ok = 1'b0;
        if (i_rd_en && (r_occ != OCC_EMPTY)) begin
            w_rd_ok = 1'b1;
        end else begin
            w_rd_ok = 1'b0;
        end
        if (i_wr_en && ((r_occ != OCC_FULL) || w_rd_ok)) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end
    end

    // Next occupancy: simultaneous write and read leave it unchanged.
    always_comb begin
        w_occ_next = r_occ;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= OCC_EMPTY;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ <= w_occ_next;
        end
    end

    assign o_occ     = r_occ;
    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through adapter for a FIFO read port with one cycle of
// read latency. Tracks the pop issued last cycle (inflight) and only requests
// a new word when the 2-entry buffer is guaranteed to have room for it.
// Optional feature macro: FIFO_RD_FWFT_CNT_EN adds a 32-bit rd_count output
// counting words accepted on the stream side.
module fifo_rd_fwft
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  read_clk,
    input  logic                  read_rst_n,
    input  logic                  p_read_empty,
    input  logic [DATA_WIDTH-1:0] p_read_data,
    output logic                  p_read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_FWFT_CNT_EN
    ,
    output logic [31:0]           rd_count
`endif
);

    logic       r_inflight;
    occ_t       w_occ;
    logic       w_pop;
    logic [2:0] w_level;
    logic       w_issue;

    assign m_valid = (w_occ != OCC_EMPTY);
    assign w_pop   = m_valid && m_ready;

    // Pop request: only when the FIFO has data and the word is sure to fit.
    // Reset gates the request so nothing is popped while held in reset.
    always_comb begin
        w_level = fwft_level(w_occ, r_inflight, w_pop);
        if (read_rst_n && !p_read_empty && (w_level < LEVEL_LIMIT)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    assign p_read_en = w_issue;

    // Remember a pop so its data is captured on the following edge.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    fifo_rd_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .i_wr_en   (r_inflight),
        .i_wr_data (p_read_data),
        .i_rd_en   (w_pop),
        .o_occ     (w_occ),
        .o_rd_data (m_data)
    );

`ifdef FIFO_RD_FWFT_CNT_EN
    logic [31:0] r_rd_count;

    // Count accepted stream words; wraps naturally at 2^32.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_rd_count <= 32'd0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 32'd1;
        end else begin
            r_rd_count <= r_rd_count;
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Scoreboard bench for fifo_rd_fwft. A behavioural FIFO source pops words
// from a queue whenever the DUT requests one; each popped word is pushed into
// the expected queue together with the cycle it must first become visible
// (two cycles after the request). A monitor on the falling edge checks
// m_valid, m_data, p_read_en and (optionally) rd_count against that model.
module tb_fifo_rd_fwft;

    localparam int DW = 8;

    logic          read_clk = 1'b0;
    logic          read_rst_n;
    logic          p_read_empty;
    logic [DW-1:0] p_read_data;
    logic          p_read_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_FWFT_CNT_EN
    logic [31:0]   rd_count;
`endif

    fifo_rd_fwft #(.DATA_WIDTH(DW)) dut (
        .read_clk     (read_clk),
        .read_rst_n   (read_rst_n),
        .p_read_empty (p_read_empty),
        .p_read_data  (p_read_data),
        .p_read_en    (p_read_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_RD_FWFT_CNT_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    always #5 read_clk = ~read_clk;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_acc = 0;
    int            dut_acc = 0;
    int            cnt_model = 0;
    bit            exp_v;
    bit            exp_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare DUT outputs with the reference model mid-cycle.
    always @(negedge read_clk) begin
        if (!read_rst_n) begin
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_m_data", {24'd0, m_data}, 32'd0);
            chk("rst_p_read_en", {31'd0, p_read_en}, 32'd0);
`ifdef FIFO_RD_FWFT_CNT_EN
            chk("rst_rd_count", rd_count, 32'd0);
`endif
        end else begin
            exp_v  = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            exp_en = !p_read_empty &&
                     ((exp_q.size() - ((exp_v && m_ready) ? 1 : 0)) < 2);
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
            chk("p_read_en", {31'd0, p_read_en}, {31'd0, exp_en});
`ifdef FIFO_RD_FWFT_CNT_EN
            chk("rd_count", rd_count, cnt_model);
`endif
            if (m_valid && m_ready) dut_acc++;
            if (exp_v) begin
                chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0].data});
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    n_acc++;
                    cnt_model++;
                end
            end
        end
    end

    // One clock of stimulus: act as the FIFO source and set the consumer.
    task automatic step(input bit ready, input bit force_empty);
        bit            iss_ok;
        logic [DW-1:0] w;
        @(negedge read_clk);
        iss_ok = p_read_en && read_rst_n && (src_q.size() > 0);
        w = iss_ok ? src_q.pop_front() : DW'($urandom);
        @(posedge read_clk);
        #1;
        cyc++;
        if (iss_ok) exp_q.push_back('{w, cyc + 1});
        p_read_data  = iss_ok ? w : DW'($urandom);
        m_ready      = ready;
        p_read_empty = force_empty || (src_q.size() == 0);
    endtask

    // Hold reset for n cycles; anything buffered or in flight is discarded.
    task automatic do_reset(input int n);
        @(posedge read_clk);
        #1;
        read_rst_n = 1'b0;
        exp_q.delete();
        cnt_model = 0;
        cyc++;
        p_read_data = DW'($urandom);
        repeat (n) begin
            @(posedge read_clk);
            #1;
            cyc++;
        end
        p_read_empty = (src_q.size() == 0);
        read_rst_n   = 1'b1;
    endtask

    initial begin
        read_rst_n   = 1'b0;
        m_ready      = 1'b1;
        p_read_empty = 1'b1;
        p_read_data  = '0;
        // Basic flow: three words, consumer always ready.
        for (int i = 1; i <= 3; i++) src_q.push_back(DW'(i));
        repeat (2) begin
            @(posedge read_clk);
            #1;
            cyc++;
        end
        p_read_empty = 1'b0;
        read_rst_n   = 1'b1;
        repeat (8) step(1'b1, 1'b0);

        // Back-pressure with four words waiting, then release.
        for (int i = 0; i < 4; i++) src_q.push_back(DW'(8'h41 + i));
        repeat (8) step(1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0);

        // Consumer toggling ready every cycle over ten words.
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(8'h10 + i));
        for (int i = 0; i < 26; i++) step((i % 2) == 0, 1'b0);

        // FIFO goes empty after a single word.
        src_q.push_back(8'h5A);
        repeat (6) step(1'b1, 1'b0);

        // Reset in the middle of a back-pressured transfer.
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'h80 + i));
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        do_reset(2);
        repeat (12) step(1'b1, 1'b0);

        // Randomised traffic: sporadic refills, empty glitches, random ready.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3) == 0) src_q.push_back(DW'($urandom));
            step(($urandom % 4) != 0, ($urandom % 6) == 0);
        end
        repeat (12) step(1'b1, 1'b0);

`ifdef FIFO_RD_FWFT_CNT_EN
        // Counter: five accepted words after a fresh reset, then reset clears.
        do_reset(1);
        for (int i = 0; i < 5; i++) src_q.push_back(DW'(8'hC0 + i));
        repeat (10) step(1'b1, 1'b0);
        @(negedge read_clk);
        chk("rd_count_5", rd_count, 32'd5);
        do_reset(1);
        @(negedge read_clk);
        chk("rd_count_cleared", rd_count, 32'd0);
`endif

        @(negedge read_clk);
        chk("accepted_words", dut_acc, n_acc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
